// File: rtl/prach_pkg.sv
// Shared types for the PRACH Avalon-ST framer: the paired IQ sample,
// the FIFO entry, and the position of the Q flag inside din_chn.
package prach_pkg;

    localparam int CHN_Q_BIT = 3;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } iq_t;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [3:0]   ant;
        logic [127:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/prach_sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head word. The head register
// counts toward the level, so a full FIFO holds DEPTH words in total.
module prach_sync_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mcnt_q, mcnt_d, level_q, level_d;
    logic [WIDTH-1:0] out_q;
    logic             out_vld_q, out_vld_d;
    logic             pop, load, from_mem, bypass, mem_wr;

    always_comb begin
        pop       = out_vld_q & rd_en_i;
        load      = ~out_vld_q | pop;
        from_mem  = load & (mcnt_q != '0);
        // Empty storage and a free head: the new word goes straight to the head.
        bypass    = load & (mcnt_q == '0) & wr_en_i;
        mem_wr    = wr_en_i & ~bypass;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mcnt_d    = mcnt_q;
        level_d   = level_q;
        out_vld_d = out_vld_q;
        if (mem_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            mcnt_d   = mcnt_d + CNT_ONE;
        end
        if (from_mem) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            mcnt_d   = mcnt_d - CNT_ONE;
        end
        if (wr_en_i) level_d = level_d + CNT_ONE;
        if (pop)     level_d = level_d - CNT_ONE;
        if (load)    out_vld_d = from_mem | bypass;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mcnt_q    <= '0;
            level_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mcnt_q    <= mcnt_d;
            level_q   <= level_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else if (!flush_i && from_mem) begin
            out_q <= mem[rd_ptr_q];
        end else if (!flush_i && bypass) begin
            out_q <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_wr && !flush_i) mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = out_q;
    assign rd_valid_o = out_vld_q;
    assign level_o    = level_q;

endmodule

// File: rtl/prach_avst_framer.sv
// Packs paired PRACH I/Q samples into 128-bit per-antenna Avalon-ST packets,
// admitting a packet only when the FIFO can hold all of its words.
module prach_avst_framer
    import prach_pkg::*;
#(
    parameter int NUM_ANT    = 8,
    parameter int PKT_WORDS  = 12,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                        clk_dsp,
    input  logic                        rst_dsp,
    input  logic                        sync_in,
    input  logic                        din_dv,
    input  logic [3:0]                  din_chn,
    input  logic [15:0]                 din_dq,
    output logic [127:0]                avst_source_data,
    output logic                        avst_source_valid,
    output logic [15:0]                 avst_source_channel,
    output logic                        avst_source_startofpacket,
    output logic                        avst_source_endofpacket,
    input  logic                        avst_source_ready,
    output logic [15:0]                 drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int ANT_W = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;
    localparam int WRD_W = $clog2(PKT_WORDS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = $bits(fifo_entry_t);
    localparam logic [WRD_W-1:0] LAST_W    = WRD_W'(PKT_WORDS - 1);
    localparam logic [WRD_W-1:0] WRD_ONE   = WRD_W'(1);
    localparam logic [LVL_W-1:0] PKT_LV    = LVL_W'(PKT_WORDS);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W:0]   PKT_CHK   = (LVL_W + 1)'(PKT_WORDS);
    localparam logic [LVL_W:0]   DEPTH_CHK = (LVL_W + 1)'(FIFO_DEPTH);

    logic signed [15:0] i_hold_q  [NUM_ANT];
    logic [31:0]        smp_buf_q [NUM_ANT][4];
    logic [1:0]         s_q       [NUM_ANT];
    logic [WRD_W-1:0]   w_q       [NUM_ANT];
    logic [NUM_ANT-1:0] i_pend_q, adm_q;
    logic [LVL_W-1:0]   rsv_q, rsv_d;
    logic [15:0]        drop_q;
    logic               push_vld_q;
    fifo_entry_t        push_ent_q, ent_d;

    logic [ANT_W-1:0]   ant;
    logic               is_q, pair, first, room_ok, admit, drop, cur_adm, push_d;
    logic [1:0]         cur_s;
    logic [WRD_W-1:0]   cur_w;
    iq_t                smp;

    logic [ENT_W-1:0]   out_raw;
    fifo_entry_t        out_ent;
    logic               out_vld;
    logic [LVL_W-1:0]   level;

    always_comb begin
        ant     = din_chn[ANT_W-1:0];
        is_q    = din_chn[CHN_Q_BIT];
        cur_s   = s_q[ant];
        cur_w   = w_q[ant];
        smp.i   = i_hold_q[ant];
        smp.q   = din_dq;
        pair    = din_dv & ~sync_in & is_q & i_pend_q[ant];
        first   = pair & (cur_s == 2'd0) & (cur_w == '0);
        // Words already queued plus words promised to open packets must leave a full packet free.
        room_ok = ({1'b0, level} + {1'b0, rsv_q} + PKT_CHK) <= DEPTH_CHK;
        admit   = first & room_ok;
        drop    = first & ~room_ok;
        cur_adm = first ? room_ok : adm_q[ant];
        push_d  = pair & (cur_s == 2'd3) & cur_adm;

        ent_d.sop  = (cur_w == '0);
        ent_d.eop  = (cur_w == LAST_W);
        ent_d.ant  = 4'(ant);
        ent_d.data = {smp_buf_q[ant][0], smp_buf_q[ant][1], smp_buf_q[ant][2], smp};

        rsv_d = rsv_q;
        if (admit)      rsv_d = rsv_d + PKT_LV;
        if (push_vld_q) rsv_d = rsv_d - LVL_ONE;
    end

    // p0 -> p1: pairing, packing counters, admission and push request
    always_ff @(posedge clk_dsp) begin
        if (rst_dsp || sync_in) begin
            i_pend_q   <= '0;
            adm_q      <= '0;
            rsv_q      <= '0;
            push_vld_q <= 1'b0;
            for (int a = 0; a < NUM_ANT; a++) begin
                s_q[a] <= '0;
                w_q[a] <= '0;
            end
        end else begin
            if (din_dv && !is_q) i_pend_q[ant] <= 1'b1;
            if (pair) begin
                i_pend_q[ant] <= 1'b0;
                s_q[ant]      <= cur_s + 2'd1;
                if (first) adm_q[ant] <= room_ok;
                if (cur_s == 2'd3) w_q[ant] <= (cur_w == LAST_W) ? '0 : cur_w + WRD_ONE;
            end
            rsv_q      <= rsv_d;
            push_vld_q <= push_d;
        end
    end

    always_ff @(posedge clk_dsp) begin
        if (din_dv && !sync_in && !is_q) i_hold_q[ant] <= din_dq;
        if (pair)   smp_buf_q[ant][cur_s] <= smp;
        if (push_d) push_ent_q <= ent_d;
    end

    always_ff @(posedge clk_dsp) begin
        if (rst_dsp) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    // p1 -> p2: FIFO write and show-ahead head register
    prach_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_dsp),
        .rst_i      (rst_dsp),
        .flush_i    (sync_in),
        .wr_en_i    (push_vld_q),
        .wr_data_i  (push_ent_q),
        .rd_en_i    (avst_source_ready),
        .rd_data_o  (out_raw),
        .rd_valid_o (out_vld),
        .level_o    (level)
    );

    assign out_ent                   = fifo_entry_t'(out_raw);
    assign avst_source_data          = out_ent.data;
    assign avst_source_valid         = out_vld;
    assign avst_source_channel       = {12'd0, out_ent.ant};
    assign avst_source_startofpacket = out_ent.sop;
    assign avst_source_endofpacket   = out_ent.eop;
    assign drop_cnt                  = drop_q;
    assign fifo_level                = level;

endmodule

// File: tb/tb_prach_avst_framer.sv
// Directed bench for prach_avst_framer: single packet, interleaved antennas,
// backpressure with admission drops, sync_in, orphan/overwrite and reset.
module tb_prach_avst_framer;

    localparam int PKT = 12;

    logic         clk = 1'b0;
    logic         rst_dsp, sync_in, din_dv, ready;
    logic [3:0]   din_chn;
    logic [15:0]  din_dq;
    logic [127:0] data;
    logic         valid, sop, eop;
    logic [15:0]  channel, drop_cnt;
    logic [7:0]   fifo_level;

    int n_total = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_unstable = 0;
    logic [145:0] mon_q [$];
    logic         hold_prev = 1'b0;
    logic         ctl_prev = 1'b0;
    logic [146:0] snap_prev = '0;

    always #5 clk = ~clk;

    prach_avst_framer dut (
        .clk_dsp                   (clk),
        .rst_dsp                   (rst_dsp),
        .sync_in                   (sync_in),
        .din_dv                    (din_dv),
        .din_chn                   (din_chn),
        .din_dq                    (din_dq),
        .avst_source_data          (data),
        .avst_source_valid         (valid),
        .avst_source_channel       (channel),
        .avst_source_startofpacket (sop),
        .avst_source_endofpacket   (eop),
        .avst_source_ready         (ready),
        .drop_cnt                  (drop_cnt),
        .fifo_level                (fifo_level)
    );

    // Record every transfer and flag any change of the held outputs under backpressure.
    always @(negedge clk) begin
        if (hold_prev && !ctl_prev && ({valid, sop, eop, channel, data} !== snap_prev))
            n_unstable++;
        hold_prev = valid & ~ready;
        ctl_prev  = rst_dsp | sync_in;
        snap_prev = {valid, sop, eop, channel, data};
        if (valid && ready) mon_q.push_back({sop, eop, channel, data});
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic dv, logic [3:0] chn, logic [15:0] dq);
        din_dv  = dv;
        din_chn = chn;
        din_dq  = dq;
        tick();
        din_dv  = 1'b0;
    endtask

    task automatic pair(int a, int j);
        drv(1'b1, {1'b0, 3'(a)}, 16'(a * 1000 + j));
        drv(1'b1, {1'b1, 3'(a)}, 16'(-j));
    endtask

    task automatic rounds(int j_last);
        for (int j = 1; j <= j_last; j++) begin
            for (int a = 0; a < 8; a++) drv(1'b1, {1'b0, 3'(a)}, 16'(a * 1000 + j));
            for (int a = 0; a < 8; a++) drv(1'b1, {1'b1, 3'(a)}, 16'(-j));
        end
    endtask

    task automatic sync_pulse();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        mon_q.delete();
    endtask

    // Word n of antenna a carries samples j = 4n+1 .. 4n+4, first sample in the MSBs.
    function automatic logic [127:0] exp_word(int a, int n);
        logic [127:0] w;
        int j;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            j = 4 * n + k + 1;
            w[127 - 32 * k -: 32] = {16'(a * 1000 + j), 16'(-j)};
        end
        return w;
    endfunction

    task automatic verify(string tag, input int cnt [8]);
        int n [8];
        int a;
        logic [145:0] e;
        for (int i = 0; i < 8; i++) n[i] = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            e = mon_q[i];
            a = int'(e[130:128]);
            chk({tag, "_chn_hi"}, e[143:131], '0);
            chk({tag, "_data"}, e[127:0], exp_word(a, n[a]));
            chk({tag, "_sop"}, e[145], (n[a] % PKT) == 0);
            chk({tag, "_eop"}, e[144], (n[a] % PKT) == PKT - 1);
            n[a]++;
        end
        for (int i = 0; i < 8; i++) chk({tag, "_cnt"}, n[i], cnt[i]);
        mon_q.delete();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_sop"}, sop, 1'b0);
        chk({tag, "_eop"}, eop, 1'b0);
        chk({tag, "_data"}, data, '0);
        chk({tag, "_chn"}, channel, '0);
        chk({tag, "_level"}, fifo_level, '0);
        chk({tag, "_drop"}, drop_cnt, '0);
    endtask

    initial begin
        int cnt [8];
        rst_dsp = 1'b1;
        sync_in = 1'b0;
        din_dv  = 1'b0;
        din_chn = '0;
        din_dq  = '0;
        ready   = 1'b1;
        repeat (3) tick();
        rst_dsp = 1'b0;
        chk_reset("rst");

        // Single packet on antenna 0, I=k, Q=-k
        for (int k = 1; k <= 4; k++) pair(0, k);
        chk("t1_lat_early", valid, 1'b0);
        tick();
        chk("t1_lat_valid", valid, 1'b1);
        chk("t1_w0_msb", data[127:96], 32'h0001_FFFF);
        chk("t1_w0_full", data, 128'h0001FFFF_0002FFFE_0003FFFD_0004FFFC);
        chk("t1_w0_sop", sop, 1'b1);
        chk("t1_w0_chn", channel, 16'd0);
        for (int k = 5; k <= 48; k++) pair(0, k);
        repeat (4) tick();
        cnt = '{12, 0, 0, 0, 0, 0, 0, 0};
        verify("t1", cnt);
        chk("t1_drop", drop_cnt, 16'd0);

        // All eight antennas interleaved
        sync_pulse();
        rounds(48);
        repeat (4) tick();
        cnt = '{12, 12, 12, 12, 12, 12, 12, 12};
        verify("t2", cnt);
        chk("t2_drop", drop_cnt, 16'd0);
        chk("t2_level", fifo_level, 8'd0);

        // Backpressure: 24 packets offered, 10 admitted, 14 dropped
        sync_pulse();
        ready = 1'b0;
        rounds(144);
        repeat (4) tick();
        chk("t3_level", fifo_level, 8'd120);
        chk("t3_drop", drop_cnt, 16'd14);
        chk("t3_stable", n_unstable, 0);
        chk("t3_head_valid", valid, 1'b1);
        chk("t3_head_sop", sop, 1'b1);
        chk("t3_head_chn", channel, 16'd0);
        chk("t3_head_data", data, exp_word(0, 0));
        chk("t3_no_xfer", mon_q.size(), 0);
        ready = 1'b1;
        repeat (130) tick();
        cnt = '{24, 24, 12, 12, 12, 12, 12, 12};
        verify("t3", cnt);
        chk("t3_level_drained", fifo_level, 8'd0);

        // sync_in during word 5 of antenna 0, with a sample in the same cycle
        sync_pulse();
        for (int k = 1; k <= 22; k++) pair(0, k);
        din_dv  = 1'b1;
        din_chn = 4'h0;
        din_dq  = 16'h5555;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        din_dv  = 1'b0;
        chk("t4_valid_off", valid, 1'b0);
        chk("t4_level", fifo_level, 8'd0);
        chk("t4_words_before", mon_q.size(), 5);
        mon_q.delete();
        drv(1'b1, 4'h8, 16'(-999));
        for (int k = 1; k <= 48; k++) pair(0, k);
        repeat (4) tick();
        cnt = '{12, 0, 0, 0, 0, 0, 0, 0};
        verify("t4", cnt);

        // Orphan Q, then I,I,Q on antenna 2
        sync_pulse();
        drv(1'b1, 4'hA, 16'h7777);
        drv(1'b1, 4'h2, 16'h1111);
        drv(1'b1, 4'h2, 16'd2001);
        drv(1'b1, 4'hA, 16'hFFFF);
        for (int k = 2; k <= 48; k++) pair(2, k);
        repeat (4) tick();
        chk("t5_first_smp", mon_q.size() > 0 ? mon_q[0][127:96] : 32'h0, 32'h07D1_FFFF);
        cnt = '{0, 0, 12, 0, 0, 0, 0, 0};
        verify("t5", cnt);

        // Reset in the middle of a stalled packet
        sync_pulse();
        ready = 1'b0;
        for (int k = 1; k <= 8; k++) pair(0, k);
        repeat (3) tick();
        chk("t6_level_pre", fifo_level, 8'd2);
        chk("t6_valid_pre", valid, 1'b1);
        chk("t6_drop_kept", drop_cnt, 16'd14);
        rst_dsp = 1'b1;
        tick();
        rst_dsp = 1'b0;
        chk_reset("t6");
        ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
